mempool_tcdm_rob: RTL and testbench

//  Reorder buffer between the Snitch core-complex TCDM data port and the tile interconnect.

---
 rtl/mempool_tcdm_rob_pkg.sv | 25 ++
 rtl/mempool_tcdm_rob_stats.sv | 22 ++
 rtl/mempool_tcdm_rob.sv | 142 ++++++++++++++
 tb/tb_mempool_tcdm_rob.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mempool_tcdm_rob_pkg.sv
// Shared types for the TCDM reorder buffer: slot layout, id widths, tracked-request test.
// Everything here is pure type/constant definitions with no logic or state.
package mempool_tcdm_rob_pkg;

    localparam int unsigned NumRobOutstanding = 8;
    localparam int unsigned MetaIdWidth       = 8;
    localparam int unsigned DataWidth         = 32;

    typedef logic [MetaIdWidth-1:0]               meta_id_t;
    typedef logic [$clog2(NumRobOutstanding)-1:0] rob_idx_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
        meta_id_t             core_id;
        logic                 pending;
        logic                 done;
    } rob_slot_t;

    // Loads and AMOs return data; plain stores are fire-and-forget.
    function automatic logic is_tracked(input logic write, input logic [3:0] amo);
        return !write || (amo != 4'd0);
    endfunction

endpackage

// File: rtl/mempool_tcdm_rob_stats.sv
// Saturating 32-bit count of cycles a tracked request is held off by a full ROB.
// One cycle from stall to visible count; no backpressure.
module mempool_tcdm_rob_stats (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_stall,
    output logic [31:0] o_count
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_stall && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/mempool_tcdm_rob.sv
// In-order response ROB between core TCDM port and tile interconnect; request path is zero-latency, responses >=1 cycle.
// Tracked requests stall when all slots are in use (registered count, no same-cycle fall-through); stall stats under MEMPOOL_TCDM_ROB_STATS_EN.
module mempool_tcdm_rob
    import mempool_tcdm_rob_pkg::*;
#(
    parameter int unsigned NumOutstanding = NumRobOutstanding
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          core_qaddr_i,
    input  logic                 core_qwrite_i,
    input  logic [3:0]           core_qamo_i,
    input  logic [DataWidth-1:0] core_qdata_i,
    input  logic [3:0]           core_qstrb_i,
    input  meta_id_t             core_qid_i,
    input  logic                 core_qvalid_i,
    output logic                 core_qready_o,
    output logic [DataWidth-1:0] core_pdata_o,
    output logic                 core_perror_o,
    output meta_id_t             core_pid_o,
    output logic                 core_pvalid_o,
    input  logic                 core_pready_i,
    output logic [31:0]          tile_qaddr_o,
    output logic                 tile_qwrite_o,
    output logic [3:0]           tile_qamo_o,
    output logic [DataWidth-1:0] tile_qdata_o,
    output logic [3:0]           tile_qstrb_o,
    output meta_id_t             tile_qid_o,
    output logic                 tile_qvalid_o,
    input  logic                 tile_qready_i,
    input  logic [DataWidth-1:0] tile_pdata_i,
    input  logic                 tile_perror_i,
    input  meta_id_t             tile_pid_i,
    input  logic                 tile_pvalid_i,
    output logic                 tile_pready_o,
    output logic [31:0]          rob_stall_o
);

    localparam int unsigned IdxW = $clog2(NumOutstanding);
    localparam int unsigned CntW = IdxW + 1;

    rob_slot_t       r_slot [NumOutstanding];
    logic [IdxW-1:0] r_head;
    logic [IdxW-1:0] r_tail;
    logic [CntW-1:0] r_count;

    logic            w_tracked;
    logic            w_full;
    logic            w_gate;
    logic            w_alloc;
    logic            w_pop;
    logic            w_pid_ok;
    logic            w_rsp_hit;
    logic [IdxW-1:0] w_rsp_idx;
    rob_slot_t       w_new_slot;
    rob_slot_t       w_head_slot;

    assign w_tracked = is_tracked(core_qwrite_i, core_qamo_i);
    assign w_full    = (r_count == CntW'(NumOutstanding));
    assign w_gate    = !w_tracked || !w_full;

    assign tile_qaddr_o  = core_qaddr_i;
    assign tile_qwrite_o = core_qwrite_i;
    assign tile_qamo_o   = core_qamo_i;
    assign tile_qdata_o  = core_qdata_i;
    assign tile_qstrb_o  = core_qstrb_i;
    assign tile_qid_o    = w_tracked ? meta_id_t'(r_tail) : '0;
    assign tile_qvalid_o = core_qvalid_i && w_gate;
    assign core_qready_o = tile_qready_i && w_gate;
    assign tile_pready_o = 1'b1;

    assign w_alloc = core_qvalid_i && core_qready_o && w_tracked;

    // Ids outside the slot range can never be pending, so they are dropped too.
    assign w_pid_ok  = (32'(tile_pid_i) < NumOutstanding);
    assign w_rsp_idx = tile_pid_i[IdxW-1:0];
    assign w_rsp_hit = tile_pvalid_i && w_pid_ok && r_slot[w_rsp_idx].pending;

    assign w_head_slot   = r_slot[r_head];
    assign core_pvalid_o = w_head_slot.done;
    assign core_pdata_o  = w_head_slot.data;
    assign core_perror_o = w_head_slot.error;
    assign core_pid_o    = w_head_slot.core_id;
    assign w_pop         = core_pvalid_o && core_pready_i;

    always_comb begin
        w_new_slot         = '0;
        w_new_slot.core_id = core_qid_i;
        w_new_slot.pending = 1'b1;
    end

    // Alloc and pop never target the same slot: equal pointers imply empty (no pop) or full (no alloc).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumOutstanding; i++) begin
                r_slot[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_rsp_hit) begin
                r_slot[w_rsp_idx].data  <= tile_pdata_i;
                r_slot[w_rsp_idx].error <= tile_perror_i;
                r_slot[w_rsp_idx].done  <= 1'b1;
            end
            if (w_pop) begin
                r_slot[r_head] <= '0;
                r_head         <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_slot[r_tail] <= w_new_slot;
                r_tail         <= r_tail + 1'b1;
            end
            r_count <= r_count + CntW'(w_alloc) - CntW'(w_pop);
        end
    end

`ifdef MEMPOOL_TCDM_ROB_STATS_EN
    logic w_stall;
    assign w_stall = core_qvalid_i && w_tracked && w_full;

    mempool_tcdm_rob_stats u_stats (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_stall (w_stall),
        .o_count (rob_stall_o)
    );
`else
    assign rob_stall_o = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && tile_pvalid_i) begin
            assert (w_rsp_hit)
            else $warning("mempool_tcdm_rob: response for non-pending slot %0d dropped", tile_pid_i);
        end
    end
`endif

endmodule

// File: tb/tb_mempool_tcdm_rob.sv
// Randomized + directed bench for mempool_tcdm_rob against an issue-order queue model.
// Inputs driven 1 time unit after posedge, outputs compared on the negedge.
module tb_mempool_tcdm_rob;
    import mempool_tcdm_rob_pkg::*;

    localparam int N = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] core_qaddr_i;
    logic        core_qwrite_i;
    logic [3:0]  core_qamo_i;
    logic [31:0] core_qdata_i;
    logic [3:0]  core_qstrb_i;
    meta_id_t    core_qid_i;
    logic        core_qvalid_i;
    logic        core_qready_o;
    logic [31:0] core_pdata_o;
    logic        core_perror_o;
    meta_id_t    core_pid_o;
    logic        core_pvalid_o;
    logic        core_pready_i;
    logic [31:0] tile_qaddr_o;
    logic        tile_qwrite_o;
    logic [3:0]  tile_qamo_o;
    logic [31:0] tile_qdata_o;
    logic [3:0]  tile_qstrb_o;
    meta_id_t    tile_qid_o;
    logic        tile_qvalid_o;
    logic        tile_qready_i;
    logic [31:0] tile_pdata_i;
    logic        tile_perror_i;
    meta_id_t    tile_pid_i;
    logic        tile_pvalid_i;
    logic        tile_pready_o;
    logic [31:0] rob_stall_o;

    always #5 clk_i = ~clk_i;

    mempool_tcdm_rob dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_qaddr_i(core_qaddr_i), .core_qwrite_i(core_qwrite_i), .core_qamo_i(core_qamo_i),
        .core_qdata_i(core_qdata_i), .core_qstrb_i(core_qstrb_i), .core_qid_i(core_qid_i),
        .core_qvalid_i(core_qvalid_i), .core_qready_o(core_qready_o),
        .core_pdata_o(core_pdata_o), .core_perror_o(core_perror_o), .core_pid_o(core_pid_o),
        .core_pvalid_o(core_pvalid_o), .core_pready_i(core_pready_i),
        .tile_qaddr_o(tile_qaddr_o), .tile_qwrite_o(tile_qwrite_o), .tile_qamo_o(tile_qamo_o),
        .tile_qdata_o(tile_qdata_o), .tile_qstrb_o(tile_qstrb_o), .tile_qid_o(tile_qid_o),
        .tile_qvalid_o(tile_qvalid_o), .tile_qready_i(tile_qready_i),
        .tile_pdata_i(tile_pdata_i), .tile_perror_i(tile_perror_i), .tile_pid_i(tile_pid_i),
        .tile_pvalid_i(tile_pvalid_i), .tile_pready_o(tile_pready_o), .rob_stall_o(rob_stall_o)
    );

`ifdef MEMPOOL_TCDM_ROB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference: outstanding tracked requests in issue order; slot = issue number mod N.
    typedef struct {
        logic [7:0]  id;
        int          slot;
        bit          done;
        logic [31:0] data;
        bit          err;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    int unsigned m_stall;
    logic [7:0]  dut_pops[$];

    task automatic idle();
        core_qvalid_i = 1'b0; core_qwrite_i = 1'b0; core_qamo_i = 4'd0;
        core_qaddr_i = $urandom; core_qdata_i = $urandom; core_qstrb_i = 4'hF; core_qid_i = '0;
        core_pready_i = 1'b1; tile_qready_i = 1'b1;
        tile_pvalid_i = 1'b0; tile_pid_i = '0; tile_pdata_i = '0; tile_perror_i = 1'b0;
    endtask

    task automatic load(input logic [7:0] id);
        core_qvalid_i = 1'b1; core_qwrite_i = 1'b0; core_qamo_i = 4'd0; core_qid_i = id;
        core_qaddr_i = $urandom; core_qdata_i = $urandom; core_qstrb_i = 4'($urandom);
    endtask

    task automatic respond(input int slot, input logic [31:0] data, input bit err);
        tile_pvalid_i = 1'b1; tile_pid_i = 8'(slot); tile_pdata_i = data; tile_perror_i = err;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        #7;
        mq.delete(); m_tail = 0; m_stall = 0;
        check("rst_pvalid", core_pvalid_o, 0);
        check("rst_tqvalid", tile_qvalid_o, 0);
        check("rst_stall", rob_stall_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    // One clock: compare every output against the model, then advance the model.
    task automatic step();
        bit trk, full, exp_qrdy, exp_pvld;
        @(negedge clk_i);
        trk      = !core_qwrite_i || (core_qamo_i != 4'd0);
        full     = (mq.size() == N);
        exp_qrdy = tile_qready_i && (!trk || !full);
        exp_pvld = (mq.size() > 0) && mq[0].done;
        check("qready", core_qready_o, exp_qrdy);
        check("tqvalid", tile_qvalid_o, core_qvalid_i && (!trk || !full));
        if (core_qvalid_i) begin
            check("tqid", tile_qid_o, trk ? m_tail : 0);
            check("tqaddr", tile_qaddr_o, core_qaddr_i);
            check("tqctl", {tile_qwrite_o, tile_qamo_o, tile_qstrb_o}, {core_qwrite_i, core_qamo_i, core_qstrb_i});
            check("tqdata", tile_qdata_o, core_qdata_i);
        end
        check("pvalid", core_pvalid_o, exp_pvld);
        if (exp_pvld) begin
            check("pid", core_pid_o, mq[0].id);
            check("pdata", core_pdata_o, mq[0].data);
            check("perror", core_perror_o, mq[0].err);
        end
        check("stall", rob_stall_o, StatsEn ? m_stall : 0);
        check("tpready", tile_pready_o, 1);
        if (core_pvalid_o && core_pready_i) dut_pops.push_back(core_pid_o);
        @(posedge clk_i);
        if (tile_pvalid_i) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].slot == int'(tile_pid_i) && !mq[i].done) begin
                    mq[i].done = 1'b1; mq[i].data = tile_pdata_i; mq[i].err = tile_perror_i;
                    break;
                end
            end
        end
        if (exp_pvld && core_pready_i) void'(mq.pop_front());
        if (core_qvalid_i && exp_qrdy && trk) begin
            mq.push_back('{id: core_qid_i, slot: m_tail, done: 1'b0, data: '0, err: 1'b0});
            m_tail = (m_tail + 1) % N;
        end
        if (core_qvalid_i && trk && full) m_stall++;
        #1;
    endtask

    task automatic drain();
        int pend[$];
        idle();
        for (int c = 0; c < 64 && mq.size() > 0; c++) begin
            pend.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].done) pend.push_back(i);
            if (pend.size() > 0) respond(mq[pend[$urandom_range(0, pend.size() - 1)]].slot, $urandom, 1'($urandom));
            else tile_pvalid_i = 1'b0;
            step();
        end
        idle();
        step();
        check("drain_pvalid", core_pvalid_o, 0);
    endtask

    initial begin
        logic [31:0] held;
        int pend[$];

        do_reset();

        // 1: out-of-order tile responses come back in issue order
        for (int i = 0; i < 3; i++) begin load(8'(5 + i)); step(); end
        idle();
        respond(2, 32'hA000_0002, 1'b0); step();
        respond(0, 32'hA000_0000, 1'b0); step();
        respond(1, 32'hA000_0001, 1'b0); step();
        tile_pvalid_i = 1'b0;
        repeat (4) step();
        check("t1_npops", dut_pops.size(), 3);
        for (int i = 0; i < 3; i++)
            check("t1_order", (dut_pops.size() > i) ? dut_pops[i] : 8'hFF, 5 + i);

        // 2: full ROB blocks loads but not stores
        do_reset();
        for (int i = 0; i < N; i++) begin load(8'(16 + i)); step(); end
        load(8'h09); #1;
        check("t2_full_rdy", core_qready_o, 0);
        step(); step();
        core_qwrite_i = 1'b1; #1;
        check("t2_store_rdy", core_qready_o, 1);
        check("t2_store_id", tile_qid_o, 0);
        step();

        // 3: a pop at T frees a slot only for T+1
        load(8'h20); respond(0, 32'h1234_5678, 1'b0); step();
        tile_pvalid_i = 1'b0; #1;
        check("t3_pvld_T", core_pvalid_o, 1);
        check("t3_rdy_T", core_qready_o, 0);
        step();
        #1;
        check("t3_rdy_T1", core_qready_o, 1);
        check("t3_qid_T1", tile_qid_o, 0);
        step();
        drain();

        // 4: error response visible one cycle after tile handshake
        do_reset();
        load(8'h01); step();
        idle(); core_pready_i = 1'b0;
        respond(0, 32'hDEAD_BEEF, 1'b1); #1;
        check("t4_pvld_same", core_pvalid_o, 0);
        step();
        tile_pvalid_i = 1'b0; #1;
        check("t4_pvld", core_pvalid_o, 1);
        check("t4_perr", core_perror_o, 1);
        check("t4_pdata", core_pdata_o, 32'hDEAD_BEEF);
        core_pready_i = 1'b1; step();

        // 5: backpressure holds payload; tail wraps from slot 7 to 0
        dut_pops.delete();
        for (int i = 0; i < N; i++) begin load(8'(8'h40 + i)); step(); end
        idle(); core_pready_i = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin respond((1 + k) % N, 32'hB000_0000 + k, 1'b0); step(); end
        tile_pvalid_i = 1'b0; #1;
        held = core_pdata_o;
        for (int c = 0; c < 4; c++) begin
            step(); #1;
            check("t5_hold", core_pdata_o, held);
        end
        core_pready_i = 1'b1;
        repeat (10) step();
        check("t5_npops", dut_pops.size(), N);
        for (int i = 0; i < N; i++)
            check("t5_order", (dut_pops.size() > i) ? dut_pops[i] : 8'hFF, 8'h40 + i);

        // 6: reset discards in-flight work; late response is dropped
        for (int i = 0; i < 4; i++) begin load(8'(8'h60 + i)); step(); end
        do_reset();
        respond(2, 32'h5555_AAAA, 1'b0); step();
        tile_pvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin #1; check("t6_pvld", core_pvalid_o, 0); step(); end

        // random traffic
        for (int c = 0; c < 600; c++) begin
            core_qvalid_i = ($urandom_range(0, 3) != 0);
            core_qwrite_i = ($urandom_range(0, 3) == 0);
            core_qamo_i   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            core_qid_i    = 8'($urandom);
            core_qaddr_i  = $urandom; core_qdata_i = $urandom; core_qstrb_i = 4'($urandom);
            tile_qready_i = ($urandom_range(0, 4) != 0);
            core_pready_i = ($urandom_range(0, 3) != 0);
            pend.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].done) pend.push_back(i);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1)
                respond(mq[pend[$urandom_range(0, pend.size() - 1)]].slot, $urandom, 1'($urandom));
            else
                tile_pvalid_i = 1'b0;
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
